// File: rtl/h14tx_period_sequencer_pkg.sv
// Shared types and TMDS constants for the HDMI 1.4 period sequencer.
package h14tx_pkg;

  typedef logic [9:0] symbol_t;

  typedef enum logic {
    PERIOD_VIDEO  = 1'b0,
    PERIOD_ISLAND = 1'b1
  } period_e;

  typedef enum logic [2:0] {
    ST_CTRL,
    ST_PREAMBLE,
    ST_LEAD_GUARD,
    ST_PAYLOAD,
    ST_TRAIL_GUARD
  } state_e;

  localparam symbol_t CTRL_00 = 10'b1101010100;
  localparam symbol_t CTRL_01 = 10'b0010101011;
  localparam symbol_t CTRL_10 = 10'b0101010100;
  localparam symbol_t CTRL_11 = 10'b1010101011;

  localparam symbol_t GUARD_VID_02 = 10'b1011001100;
  localparam symbol_t GUARD_VID_1  = 10'b0100110011;
  localparam symbol_t GUARD_ISL_12 = 10'b0100110011;

  function automatic symbol_t ctrl_symbol(input logic [1:0] d);
    symbol_t s;
    unique case (d)
      2'b00: s = CTRL_00;
      2'b01: s = CTRL_01;
      2'b10: s = CTRL_10;
      default: s = CTRL_11;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/h14tx_period_sequencer_if.sv
// Period request, payload handshake and TMDS symbol bundle of the sequencer.
interface h14tx_period_sequencer_if;
  import h14tx_pkg::*;

  logic          hsync;
  logic          vsync;
  logic          period_valid;
  logic          period_type;
  logic          period_ready;
  symbol_t       island_guard_sym;
  symbol_t [2:0] payload_sym;
  logic          payload_valid;
  logic          payload_last;
  logic          payload_ready;
  symbol_t [2:0] symbol;
  logic          underflow;

  modport slave (
    input  hsync, vsync, period_valid, period_type, island_guard_sym,
    input  payload_sym, payload_valid, payload_last,
    output period_ready, payload_ready, symbol, underflow
  );

  modport master (
    output hsync, vsync, period_valid, period_type, island_guard_sym,
    output payload_sym, payload_valid, payload_last,
    input  period_ready, payload_ready, symbol, underflow
  );

endinterface

// File: rtl/h14tx_period_sequencer.sv
// Sequences the three TMDS channels through control, preamble, guard-band and
// payload phases for video and data-island periods.
module h14tx_period_sequencer
  import h14tx_pkg::*;
#(
  parameter int PreambleLen = 8,
  parameter int GuardLen    = 2,
  parameter int MinCtrlLen  = 12
) (
  input  logic clk,
  input  logic rst,
  h14tx_period_sequencer_if.slave bus
);

  localparam int CntMax = (PreambleLen > GuardLen)
                        ? ((PreambleLen > MinCtrlLen) ? PreambleLen : MinCtrlLen)
                        : ((GuardLen > MinCtrlLen) ? GuardLen : MinCtrlLen);
  localparam int CntW = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] CtrlSat   = CntW'(MinCtrlLen - PreambleLen);
  localparam logic [CntW-1:0] PreLast   = CntW'(PreambleLen - 1);
  localparam logic [CntW-1:0] GuardLast = CntW'(GuardLen - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] ctrl_cnt_q, ctrl_cnt_d;
  logic [CntW-1:0] phase_q, phase_d;
  period_e         type_q, type_d;
  logic            underflow_q, underflow_d;
  symbol_t [2:0]   symbol_q, symbol_d;

  assign bus.period_ready  = (state_q == ST_CTRL) && (ctrl_cnt_q == CtrlSat);
  assign bus.payload_ready = (state_q == ST_PAYLOAD);
  assign bus.symbol        = symbol_q;
  assign bus.underflow     = underflow_q;

  always_comb begin
    state_d     = state_q;
    ctrl_cnt_d  = ctrl_cnt_q;
    phase_d     = phase_q;
    type_d      = type_q;
    underflow_d = underflow_q;
    // Control characters are the fallback for CTRL and for payload starvation.
    symbol_d[0] = ctrl_symbol({bus.vsync, bus.hsync});
    symbol_d[1] = CTRL_00;
    symbol_d[2] = CTRL_00;

    unique case (state_q)
      ST_CTRL: begin
        if (ctrl_cnt_q != CtrlSat) ctrl_cnt_d = ctrl_cnt_q + CntW'(1);
        if (bus.period_valid && bus.period_ready) begin
          type_d  = bus.period_type ? PERIOD_ISLAND : PERIOD_VIDEO;
          state_d = ST_PREAMBLE;
          phase_d = '0;
        end
      end
      ST_PREAMBLE: begin
        symbol_d[1] = CTRL_01;
        symbol_d[2] = (type_q == PERIOD_ISLAND) ? CTRL_01 : CTRL_00;
        phase_d     = phase_q + CntW'(1);
        if (phase_q == PreLast) begin
          state_d = ST_LEAD_GUARD;
          phase_d = '0;
        end
      end
      ST_LEAD_GUARD: begin
        if (type_q == PERIOD_ISLAND) begin
          symbol_d[0] = bus.island_guard_sym;
          symbol_d[1] = GUARD_ISL_12;
          symbol_d[2] = GUARD_ISL_12;
        end else begin
          symbol_d[0] = GUARD_VID_02;
          symbol_d[1] = GUARD_VID_1;
          symbol_d[2] = GUARD_VID_02;
        end
        phase_d = phase_q + CntW'(1);
        if (phase_q == GuardLast) begin
          state_d = ST_PAYLOAD;
          phase_d = '0;
        end
      end
      ST_PAYLOAD: begin
        if (bus.payload_valid) begin
          symbol_d = bus.payload_sym;
          if (bus.payload_last) begin
            if (type_q == PERIOD_ISLAND) begin
              state_d = ST_TRAIL_GUARD;
              phase_d = '0;
            end else begin
              state_d    = ST_CTRL;
              ctrl_cnt_d = '0;
            end
          end
        end else begin
          underflow_d = 1'b1;
        end
      end
      ST_TRAIL_GUARD: begin
        symbol_d[0] = bus.island_guard_sym;
        symbol_d[1] = GUARD_ISL_12;
        symbol_d[2] = GUARD_ISL_12;
        phase_d     = phase_q + CntW'(1);
        if (phase_q == GuardLast) begin
          state_d    = ST_CTRL;
          ctrl_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_CTRL;
        ctrl_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CTRL;
      ctrl_cnt_q  <= '0;
      phase_q     <= '0;
      type_q      <= PERIOD_VIDEO;
      underflow_q <= 1'b0;
      symbol_q    <= {CTRL_00, CTRL_00, CTRL_00};
    end else begin
      state_q     <= state_d;
      ctrl_cnt_q  <= ctrl_cnt_d;
      phase_q     <= phase_d;
      type_q      <= type_d;
      underflow_q <= underflow_d;
      symbol_q    <= symbol_d;
    end
  end

endmodule

// File: tb/tb_h14tx_period_sequencer.sv
// Scoreboard bench for h14tx_period_sequencer: directed periods with
// hand-computed per-cycle symbol, underflow and ready expectations.
module tb_h14tx_period_sequencer;
  import h14tx_pkg::*;

  localparam int PRE   = 8;
  localparam int GUARD = 2;

  localparam symbol_t C00 = 10'b1101010100;
  localparam symbol_t C01 = 10'b0010101011;
  localparam symbol_t C10 = 10'b0101010100;
  localparam symbol_t GV  = 10'b1011001100;
  localparam symbol_t G1  = 10'b0100110011;
  localparam symbol_t IGS = 10'b0101100110;

  typedef struct {
    symbol_t s0, s1, s2;
    logic    uf, pr, yr;
    string   tag;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   checks;
  int   errors;

  h14tx_period_sequencer_if bus ();

  h14tx_period_sequencer #(
    .PreambleLen(PRE),
    .GuardLen   (GUARD),
    .MinCtrlLen (12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic symbol_t pdat(input int ch, input int i);
    return symbol_t'(ch * 200 + i * 5 + 1);
  endfunction

  task automatic cmp(input string tag, input string field, input logic [9:0] got, input logic [9:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s: got %b expected %b at %0t", tag, field, got, want, $time);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.tag, "ch0", bus.symbol[0], e.s0);
      cmp(e.tag, "ch1", bus.symbol[1], e.s1);
      cmp(e.tag, "ch2", bus.symbol[2], e.s2);
      cmp(e.tag, "underflow", {9'd0, bus.underflow}, {9'd0, e.uf});
      cmp(e.tag, "period_ready", {9'd0, bus.period_ready}, {9'd0, e.pr});
      cmp(e.tag, "payload_ready", {9'd0, bus.payload_ready}, {9'd0, e.yr});
    end
  end

  task automatic tick(input symbol_t e0, e1, e2, input logic euf, epr, eyr, input string tag);
    exp_t e;
    @(posedge clk);
    e.s0 = e0; e.s1 = e1; e.s2 = e2;
    e.uf = euf; e.pr = epr; e.yr = eyr; e.tag = tag;
    exp_q.push_back(e);
    #1;
  endtask

  // Five CTRL characters starting from ctrl_cnt = 0; accept on the fifth.
  task automatic ctrl_gap(input symbol_t c0, input logic euf, input string tag);
    for (int i = 0; i < 5; i++) tick(c0, C00, C00, euf, (i == 3), 1'b0, tag);
  endtask

  task automatic preamble(input symbol_t c0, input symbol_t c2, input logic euf, input string tag);
    for (int i = 0; i < PRE; i++) tick(c0, C01, c2, euf, 1'b0, 1'b0, tag);
  endtask

  task automatic guard(input symbol_t g0, g1, g2, input logic euf, input logic last_yr, input string tag);
    for (int i = 0; i < GUARD; i++)
      tick(g0, g1, g2, euf, 1'b0, (i == GUARD - 1) ? last_yr : 1'b0, tag);
  endtask

  task automatic set_beat(input int i, input logic last);
    bus.payload_valid = 1'b1;
    bus.payload_last  = last;
    for (int c = 0; c < 3; c++) bus.payload_sym[c] = pdat(c, i);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.hsync = 1'b0;
    bus.vsync = 1'b0;
    bus.period_valid = 1'b1;
    bus.period_type = 1'b0;
    bus.island_guard_sym = IGS;
    bus.payload_valid = 1'b0;
    bus.payload_last = 1'b0;
    for (int c = 0; c < 3; c++) bus.payload_sym[c] = '0;

    tick(C00, C00, C00, 1'b0, 1'b0, 1'b0, "reset");
    tick(C00, C00, C00, 1'b0, 1'b0, 1'b0, "reset");
    rst = 1'b0;

    // Video period, hsync=1 during preamble, 3 beats.
    ctrl_gap(C00, 1'b0, "vid_ctrl");
    bus.period_valid = 1'b0;
    bus.hsync = 1'b1;
    preamble(C01, C00, 1'b0, "vid_pre");
    guard(GV, G1, GV, 1'b0, 1'b1, "vid_lead");
    for (int i = 0; i < 3; i++) begin
      set_beat(i, i == 2);
      tick(pdat(0, i), pdat(1, i), pdat(2, i), 1'b0, 1'b0, (i < 2), "vid_pay");
    end

    // Back-to-back island; payload_valid held (ignored) before PAYLOAD.
    bus.period_valid = 1'b1;
    bus.period_type = 1'b1;
    bus.hsync = 1'b0;
    bus.vsync = 1'b1;
    set_beat(0, 1'b0);
    ctrl_gap(C10, 1'b0, "isl_ctrl");
    bus.period_type = 1'b0;
    preamble(C10, C01, 1'b0, "isl_pre");
    guard(IGS, G1, G1, 1'b0, 1'b1, "isl_lead");
    for (int i = 0; i < 32; i++) begin
      set_beat(i, i == 31);
      tick(pdat(0, i), pdat(1, i), pdat(2, i), 1'b0, 1'b0, (i < 31), "isl_pay");
    end
    bus.payload_valid = 1'b0;
    bus.payload_last = 1'b0;
    guard(IGS, G1, G1, 1'b0, 1'b0, "isl_trail");

    // Back-to-back video with a one-cycle payload gap.
    bus.hsync = 1'b1;
    bus.vsync = 1'b0;
    ctrl_gap(C01, 1'b0, "uf_ctrl");
    bus.period_valid = 1'b0;
    preamble(C01, C00, 1'b0, "uf_pre");
    guard(GV, G1, GV, 1'b0, 1'b1, "uf_lead");
    set_beat(0, 1'b0);
    tick(pdat(0, 0), pdat(1, 0), pdat(2, 0), 1'b0, 1'b0, 1'b1, "uf_beat0");
    bus.payload_valid = 1'b0;
    tick(C01, C00, C00, 1'b1, 1'b0, 1'b1, "uf_gap");
    set_beat(1, 1'b0);
    tick(pdat(0, 1), pdat(1, 1), pdat(2, 1), 1'b1, 1'b0, 1'b1, "uf_beat1");
    set_beat(2, 1'b1);
    tick(pdat(0, 2), pdat(1, 2), pdat(2, 2), 1'b1, 1'b0, 1'b0, "uf_last");
    bus.payload_valid = 1'b0;
    bus.payload_last = 1'b0;

    // Reset during lead guard abandons the period and clears underflow.
    bus.hsync = 1'b0;
    bus.period_valid = 1'b1;
    ctrl_gap(C00, 1'b1, "rst_ctrl");
    preamble(C00, C00, 1'b1, "rst_pre");
    tick(GV, G1, GV, 1'b1, 1'b0, 1'b0, "rst_lead");
    rst = 1'b1;
    tick(C00, C00, C00, 1'b0, 1'b0, 1'b0, "rst_hit");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick(C00, C00, C00, 1'b0, 1'b0, 1'b0, "rst_after");
    tick(C00, C00, C00, 1'b0, 1'b1, 1'b0, "rst_ready");
    bus.period_valid = 1'b0;
    tick(C00, C00, C00, 1'b0, 1'b1, 1'b0, "rst_idle");

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
